// File: rtl/hp0_axi_rd_burst_master.sv
// AXI4 read-burst master for the HP0 AR/R channels: splits a word-count command into INCR bursts of
// at most max_burst_len_p beats that never cross 4 KB. Define HP0_RD_RLAST_CHECK_EN to flag rlast errors.
module hp0_axi_rd_burst_master #(
  parameter int C_HP0_AXI_DATA_WIDTH = 32,
  parameter int C_HP0_AXI_ADDR_WIDTH = 32,
  parameter int max_burst_len_p      = 16,
  parameter int len_width_p          = 16
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            cmd_v_i,
  input  logic [C_HP0_AXI_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [len_width_p-1:0]          cmd_words_i,
  output logic                            cmd_ready_o,
  output logic                            data_v_o,
  output logic [C_HP0_AXI_DATA_WIDTH-1:0] data_o,
  input  logic                            data_ready_i,
  output logic                            busy_o,
  output logic                            err_o,
  output logic [C_HP0_AXI_ADDR_WIDTH-1:0] hp0_axi_araddr,
  output logic                            hp0_axi_arvalid,
  input  logic                            hp0_axi_arready,
  output logic [5:0]                      hp0_axi_arid,
  output logic                            hp0_axi_arlock,
  output logic [3:0]                      hp0_axi_arcache,
  output logic [2:0]                      hp0_axi_arprot,
  output logic [7:0]                      hp0_axi_arlen,
  output logic [2:0]                      hp0_axi_arsize,
  output logic [1:0]                      hp0_axi_arburst,
  output logic [3:0]                      hp0_axi_arqos,
  input  logic [C_HP0_AXI_DATA_WIDTH-1:0] hp0_axi_rdata,
  input  logic                            hp0_axi_rvalid,
  output logic                            hp0_axi_rready,
  input  logic [5:0]                      hp0_axi_rid,
  input  logic                            hp0_axi_rlast,
  input  logic [1:0]                      hp0_axi_rresp
);

  localparam int AW     = C_HP0_AXI_ADDR_WIDTH;
  localparam int BYTES  = C_HP0_AXI_DATA_WIDTH / 8;
  localparam int SIZE   = $clog2(BYTES);
  localparam int BCNT_W = $clog2(max_burst_len_p + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e                 state, state_nxt;
  logic [AW-1:0]          addr_r;
  logic [len_width_p-1:0] remaining_r;
  logic [BCNT_W-1:0]      beat_cnt_r;
  logic                   err_r;

  logic        cmd_accept, r_hs, last_beat, err_set, rlast_err;
  logic [12:0] to4k_bytes, to4k_words;
  logic [31:0] beats;
  logic        unused_in;

  assign cmd_accept = cmd_v_i && (state == IDLE);
  assign r_hs       = (state == DATA) && hp0_axi_rvalid && data_ready_i;
  assign last_beat  = r_hs && (beat_cnt_r == BCNT_W'(1));

`ifdef HP0_RD_RLAST_CHECK_EN
  // rlast must coincide exactly with the beat the counter expects to be final.
  assign rlast_err = r_hs && (hp0_axi_rlast != (beat_cnt_r == BCNT_W'(1)));
  assign unused_in = ^hp0_axi_rid;
`else
  assign rlast_err = 1'b0;
  assign unused_in = ^{hp0_axi_rid, hp0_axi_rlast};
`endif

  assign err_set = (r_hs && (hp0_axi_rresp != 2'b00)) || rlast_err;

  // Burst size: the smallest of remaining words, the max burst, and words left in this 4 KB page.
  always_comb begin
    to4k_bytes = 13'h1000 - {1'b0, addr_r[11:0]};
    to4k_words = to4k_bytes >> SIZE;
    beats      = 32'(remaining_r);
    if (beats > 32'(max_burst_len_p)) beats = 32'(max_burst_len_p);
    if (beats > 32'(to4k_words))      beats = 32'(to4k_words);
  end

  // NOTE: next-state logic assigns its default first, so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_v_i && (cmd_words_i != '0)) state_nxt = ADDR;
      ADDR:    if (hp0_axi_arready) state_nxt = DATA;
      DATA:    if (last_beat) state_nxt = (remaining_r == len_width_p'(1)) ? IDLE : ADDR;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= IDLE;
      addr_r      <= '0;
      remaining_r <= '0;
      beat_cnt_r  <= '0;
      err_r       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cmd_accept) begin
        addr_r      <= cmd_addr_i & ~AW'(BYTES - 1);
        remaining_r <= cmd_words_i;
        err_r       <= 1'b0;
      end
      if ((state == ADDR) && hp0_axi_arready) beat_cnt_r <= BCNT_W'(beats);
      if (r_hs) begin
        beat_cnt_r  <= beat_cnt_r - BCNT_W'(1);
        remaining_r <= remaining_r - len_width_p'(1);
        addr_r      <= addr_r + AW'(BYTES);
      end
      if (err_set) err_r <= 1'b1;
    end
  end

  assign cmd_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);
  assign err_o       = err_r;

  assign hp0_axi_arvalid = (state == ADDR);
  assign hp0_axi_araddr  = addr_r;
  assign hp0_axi_arlen   = (state == ADDR) ? 8'(beats - 32'd1) : 8'd0;
  assign hp0_axi_arsize  = 3'(SIZE);
  assign hp0_axi_arburst = 2'b01;
  assign hp0_axi_arid    = 6'd0;
  assign hp0_axi_arlock  = 1'b0;
  assign hp0_axi_arcache = 4'b0011;
  assign hp0_axi_arprot  = 3'b000;
  assign hp0_axi_arqos   = 4'd0;

  // Zero-latency, unbuffered data path: backpressure goes straight to rready.
  assign hp0_axi_rready = (state == DATA) && data_ready_i;
  assign data_v_o       = (state == DATA) && hp0_axi_rvalid;
  assign data_o         = hp0_axi_rdata;

endmodule

// File: tb/tb_hp0_axi_rd_burst_master.sv
// Randomized bench for hp0_axi_rd_burst_master: an AXI read slave model plus a per-command
// reference that derives the expected bursts and data stream from address/word-count arithmetic.
module tb_hp0_axi_rd_burst_master;
  localparam int DW = 32, AW = 32, MAXB = 16, LW = 16;

  logic          aclk, areset;
  logic          cmd_v_i, cmd_ready_o, data_v_o, data_ready_i, busy_o, err_o;
  logic [AW-1:0] cmd_addr_i;
  logic [LW-1:0] cmd_words_i;
  logic [DW-1:0] data_o;
  logic [AW-1:0] hp0_axi_araddr;
  logic          hp0_axi_arvalid, hp0_axi_arready, hp0_axi_arlock;
  logic [5:0]    hp0_axi_arid, hp0_axi_rid;
  logic [3:0]    hp0_axi_arcache, hp0_axi_arqos;
  logic [2:0]    hp0_axi_arprot, hp0_axi_arsize;
  logic [7:0]    hp0_axi_arlen;
  logic [1:0]    hp0_axi_arburst, hp0_axi_rresp;
  logic [DW-1:0] hp0_axi_rdata;
  logic          hp0_axi_rvalid, hp0_axi_rready, hp0_axi_rlast;

  hp0_axi_rd_burst_master #(
    .C_HP0_AXI_DATA_WIDTH(DW), .C_HP0_AXI_ADDR_WIDTH(AW),
    .max_burst_len_p(MAXB), .len_width_p(LW)
  ) dut (
    .aclk(aclk), .areset(areset),
    .cmd_v_i(cmd_v_i), .cmd_addr_i(cmd_addr_i), .cmd_words_i(cmd_words_i), .cmd_ready_o(cmd_ready_o),
    .data_v_o(data_v_o), .data_o(data_o), .data_ready_i(data_ready_i),
    .busy_o(busy_o), .err_o(err_o),
    .hp0_axi_araddr(hp0_axi_araddr), .hp0_axi_arvalid(hp0_axi_arvalid), .hp0_axi_arready(hp0_axi_arready),
    .hp0_axi_arid(hp0_axi_arid), .hp0_axi_arlock(hp0_axi_arlock), .hp0_axi_arcache(hp0_axi_arcache),
    .hp0_axi_arprot(hp0_axi_arprot), .hp0_axi_arlen(hp0_axi_arlen), .hp0_axi_arsize(hp0_axi_arsize),
    .hp0_axi_arburst(hp0_axi_arburst), .hp0_axi_arqos(hp0_axi_arqos),
    .hp0_axi_rdata(hp0_axi_rdata), .hp0_axi_rvalid(hp0_axi_rvalid), .hp0_axi_rready(hp0_axi_rready),
    .hp0_axi_rid(hp0_axi_rid), .hp0_axi_rlast(hp0_axi_rlast), .hp0_axi_rresp(hp0_axi_rresp)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int compared   = 0;
  int mismatched = 0;

  // Slave configuration, set by each scenario before its command is accepted.
  int ar_delay = 0, ready_pct = 100, valid_pct = 100, err_beat = -1, rlast_beat = -1, exp_words = 0;
  // Slave / monitor state.
  bit          in_burst, r_hs_prev, ar_pend;
  int          ar_wait, beats_left, beat_num, cyc, final_cyc, mon_err;
  logic [31:0] cur_addr, pend_addr;
  logic [7:0]  pend_len;
  logic [31:0] obs_ar_addr[$];
  logic [7:0]  obs_ar_len[$];
  logic [31:0] obs_data[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Slave model: drives at the falling edge, evaluates handshakes 1 ns later (stable until the rising edge).
  initial begin : slave
    hp0_axi_arready = 0; hp0_axi_rvalid = 0; hp0_axi_rdata = '0; hp0_axi_rlast = 0;
    hp0_axi_rresp = 2'b00; hp0_axi_rid = '0; data_ready_i = 0;
    in_burst = 0; r_hs_prev = 0; ar_pend = 0; ar_wait = 0; beats_left = 0; beat_num = 0;
    cyc = 0; final_cyc = -1; mon_err = 0; cur_addr = '0; pend_addr = '0; pend_len = '0;
    forever begin
      @(negedge aclk);
      cyc++;
      if (areset) begin
        hp0_axi_arready = 0; hp0_axi_rvalid = 0; hp0_axi_rlast = 0; hp0_axi_rresp = 2'b00;
        data_ready_i = 0; in_burst = 0; ar_wait = 0; ar_pend = 0; r_hs_prev = 0;
        continue;
      end
      data_ready_i = ($urandom_range(99) < ready_pct);
      if (!in_burst) begin
        hp0_axi_rvalid = 0; hp0_axi_rlast = 0; hp0_axi_rresp = 2'b00;
        if (hp0_axi_arvalid) begin
          ar_wait++;
          hp0_axi_arready = (ar_wait > ar_delay);
        end else begin
          ar_wait = 0;
          hp0_axi_arready = 0;
        end
      end else begin
        hp0_axi_arready = 0;
        if (!hp0_axi_rvalid || r_hs_prev) begin
          hp0_axi_rvalid = ($urandom_range(99) < valid_pct);
          hp0_axi_rdata  = word_of(cur_addr);
          hp0_axi_rresp  = (beat_num == err_beat) ? 2'b10 : 2'b00;
          hp0_axi_rlast  = (rlast_beat >= 0) ? (beat_num == rlast_beat) : (beats_left == 1);
          hp0_axi_rid    = 6'($urandom);
        end
      end
      #1;
      r_hs_prev = 0;
      if (data_v_o !== (in_burst && hp0_axi_rvalid)) mon_err++;
      if (hp0_axi_rready !== (in_burst && data_ready_i)) mon_err++;
      if (in_burst && hp0_axi_arvalid) mon_err++;
      if (ar_pend && (!hp0_axi_arvalid || hp0_axi_araddr !== pend_addr || hp0_axi_arlen !== pend_len)) mon_err++;
      ar_pend   = hp0_axi_arvalid && !hp0_axi_arready;
      pend_addr = hp0_axi_araddr;
      pend_len  = hp0_axi_arlen;
      if (in_burst && hp0_axi_rvalid && data_ready_i) begin
        obs_data.push_back(data_o);
        beats_left--;
        cur_addr += 32'd4;
        beat_num++;
        r_hs_prev = 1;
        if (beat_num == exp_words) final_cyc = cyc;
        if (beats_left == 0) in_burst = 0;
      end else if (!in_burst && hp0_axi_arvalid && hp0_axi_arready) begin
        obs_ar_addr.push_back(hp0_axi_araddr);
        obs_ar_len.push_back(hp0_axi_arlen);
        in_burst   = 1;
        cur_addr   = hp0_axi_araddr;
        beats_left = int'(hp0_axi_arlen) + 1;
        ar_wait    = 0;
      end
    end
  end

  // One complete command: reference model, stimulus, and all end-of-command comparisons.
  task automatic run_cmd(input logic [31:0] addr, input int words, input int ard, input int rp,
                         input int vp, input int eb, input int rb, input string name);
    logic [31:0] exp_addr[$];
    int          exp_len[$];
    logic [31:0] a;
    int          rem, b, to4k, n;
    bit          exp_err, done;
    a = addr & ~32'd3;
    rem = words;
    while (rem > 0) begin
      to4k = (4096 - int'(a % 4096)) / 4;
      b = rem;
      if (b > MAXB) b = MAXB;
      if (b > to4k) b = to4k;
      exp_addr.push_back(a);
      exp_len.push_back(b - 1);
      a += 32'(b * 4);
      rem -= b;
    end
    exp_err = (eb >= 0) && (eb < words);
`ifdef HP0_RD_RLAST_CHECK_EN
    exp_err = exp_err || ((rb >= 0) && (words > 0));
`endif
    obs_ar_addr.delete(); obs_ar_len.delete(); obs_data.delete();
    ar_delay = ard; ready_pct = rp; valid_pct = vp; err_beat = eb; rlast_beat = rb;
    beat_num = 0; exp_words = words; final_cyc = -1; mon_err = 0;

    @(negedge aclk);
    cmd_v_i = 1; cmd_addr_i = addr; cmd_words_i = LW'(words);
    #2;
    compared++;
    if (cmd_ready_o !== 1'b1) begin
      mismatched++; $display("FAIL %s cmd_ready_at_accept: got %b want 1", name, cmd_ready_o);
    end
    @(negedge aclk);
    cmd_v_i = 0; cmd_addr_i = $urandom; cmd_words_i = LW'($urandom);
    #2;
    compared++;
    if (hp0_axi_arvalid !== (words != 0)) begin
      mismatched++; $display("FAIL %s arvalid_after_accept: got %b want %b", name, hp0_axi_arvalid, words != 0);
    end
    compared++;
    if (err_o !== 1'b0) begin
      mismatched++; $display("FAIL %s err_cleared_on_accept: got %b want 0", name, err_o);
    end
    compared++;
    if (busy_o !== (words != 0)) begin
      mismatched++; $display("FAIL %s busy_after_accept: got %b want %b", name, busy_o, words != 0);
    end

    if (words != 0) begin
      done = 0;
      for (int i = 0; i < 5000 && !done; i++) begin
        @(negedge aclk);
        #2;
        if (cmd_ready_o === 1'b1) done = 1;
      end
      compared++;
      if (!done) begin
        mismatched++; $display("FAIL %s completion_timeout: got busy want idle within 5000 cycles", name);
      end else begin
        compared++;
        if (cyc !== final_cyc + 1) begin
          mismatched++; $display("FAIL %s cmd_ready_timing: got cycle %0d want %0d", name, cyc, final_cyc + 1);
        end
      end
    end

    compared++;
    if (obs_ar_addr.size() !== exp_addr.size()) begin
      mismatched++; $display("FAIL %s ar_count: got %0d want %0d", name, obs_ar_addr.size(), exp_addr.size());
    end
    n = (obs_ar_addr.size() < exp_addr.size()) ? obs_ar_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      compared++;
      if (obs_ar_addr[i] !== exp_addr[i] || obs_ar_len[i] !== 8'(exp_len[i])) begin
        mismatched++;
        $display("FAIL %s ar[%0d]: got addr %h len %0d want addr %h len %0d",
                 name, i, obs_ar_addr[i], obs_ar_len[i], exp_addr[i], exp_len[i]);
      end
    end
    compared++;
    if (obs_data.size() !== words) begin
      mismatched++; $display("FAIL %s beat_count: got %0d want %0d", name, obs_data.size(), words);
    end
    n = (obs_data.size() < words) ? obs_data.size() : words;
    for (int i = 0; i < n; i++) begin
      compared++;
      if (obs_data[i] !== word_of((addr & ~32'd3) + 32'(i * 4))) begin
        mismatched++;
        $display("FAIL %s data[%0d]: got %h want %h", name, i, obs_data[i], word_of((addr & ~32'd3) + 32'(i * 4)));
      end
    end
    compared++;
    if (err_o !== exp_err) begin
      mismatched++; $display("FAIL %s err_flag: got %b want %b", name, err_o, exp_err);
    end
    compared++;
    if (mon_err !== 0) begin
      mismatched++; $display("FAIL %s handshake_protocol: got %0d violations want 0", name, mon_err);
    end
  endtask

  task automatic test_reset();
    logic [31:0] obs[15];
    logic [31:0] exp[15];
    string       nm[15];
    nm  = '{"cmd_ready", "busy", "err", "arvalid", "data_v", "rready", "araddr", "arlen",
            "arsize", "arburst", "arid", "arlock", "arcache", "arprot", "arqos"};
    exp = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
            32'd2, 32'd1, 32'd0, 32'd0, 32'd3, 32'd0, 32'd0};
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge aclk);
      #2;
      obs = '{32'(cmd_ready_o), 32'(busy_o), 32'(err_o), 32'(hp0_axi_arvalid), 32'(data_v_o),
              32'(hp0_axi_rready), hp0_axi_araddr, 32'(hp0_axi_arlen), 32'(hp0_axi_arsize),
              32'(hp0_axi_arburst), 32'(hp0_axi_arid), 32'(hp0_axi_arlock), 32'(hp0_axi_arcache),
              32'(hp0_axi_arprot), 32'(hp0_axi_arqos)};
      for (int i = 0; i < 15; i++) begin
        compared++;
        if (obs[i] !== exp[i]) begin
          mismatched++; $display("FAIL reset_%s (pass %0d): got %h want %h", nm[i], pass, obs[i], exp[i]);
        end
      end
      if (pass == 0) begin
        #1 areset = 0;
      end
    end
  endtask

  task automatic test_reset_mid_transfer();
    obs_ar_addr.delete(); obs_ar_len.delete(); obs_data.delete();
    ar_delay = 0; ready_pct = 100; valid_pct = 100; err_beat = -1; rlast_beat = -1;
    beat_num = 0; exp_words = 40;
    @(negedge aclk);
    cmd_v_i = 1; cmd_addr_i = 32'h0000_3000; cmd_words_i = LW'(40);
    @(negedge aclk);
    cmd_v_i = 0;
    repeat (6) @(negedge aclk);
    #2;
    compared++;
    if (busy_o !== 1'b1) begin
      mismatched++; $display("FAIL midreset_busy_before: got %b want 1", busy_o);
    end
    #1 areset = 1;
    #1;
    compared++;
    if ({hp0_axi_arvalid, hp0_axi_rready, data_v_o, busy_o, cmd_ready_o} !== 5'b00001) begin
      mismatched++;
      $display("FAIL midreset_outputs: got arvalid %b rready %b data_v %b busy %b cmd_ready %b want 0 0 0 0 1",
               hp0_axi_arvalid, hp0_axi_rready, data_v_o, busy_o, cmd_ready_o);
    end
    @(negedge aclk);
    #3 areset = 0;
    run_cmd(32'h0000_3000, 5, 0, 100, 100, -1, -1, "after_midreset");
  endtask

  task automatic test_random();
    logic [31:0] addr;
    int          words, eb;
    for (int k = 0; k < 20; k++) begin
      addr  = 32'($urandom_range(0, 3)) * 32'd4096 + 32'd4096 - 32'(4 * $urandom_range(0, 40))
              + 32'($urandom_range(0, 3));
      words = $urandom_range(0, 70);
      eb    = (words > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, words - 1)) : -1;
      run_cmd(addr, words, $urandom_range(0, 4), $urandom_range(30, 100), $urandom_range(30, 100),
              eb, -1, $sformatf("random%0d", k));
    end
  endtask

  initial begin
    areset = 1; cmd_v_i = 0; cmd_addr_i = '0; cmd_words_i = '0;
    test_reset();
    run_cmd(32'h0000_1000, 4, 0, 100, 100, -1, -1, "single_burst");
    run_cmd(32'h0000_2000, 40, 0, 100, 100, -1, -1, "multi_burst");
    run_cmd(32'h0000_0FF8, 8, 0, 100, 100, -1, -1, "cross_4k");
    run_cmd(32'h0000_0FFB, 3, 1, 100, 100, -1, -1, "unaligned_addr");
    run_cmd(32'h0000_4000, 0, 0, 100, 100, -1, -1, "zero_words");
    run_cmd(32'h0000_6000, 20, 3, 50, 70, 1, -1, "backpressure_err");
    run_cmd(32'h0000_7000, 6, 0, 100, 100, -1, -1, "err_clear");
    run_cmd(32'h0000_5000, 4, 0, 100, 100, -1, 2, "rlast_early");
    run_cmd(32'h0000_8000, 17, 0, 100, 100, -1, -1, "back_to_back");
    test_reset_mid_transfer();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/hp0_axi_rd_burst_master.md
# hp0_axi_rd_burst_master

AXI4 read-burst master that drives the HP0 read channels (AR/R) of `top_zynq` from a simple command/stream interface. A client issues a word address and word count; the block splits the transfer into INCR bursts that never exceed `max_burst_len_p` beats or cross a 4 KB boundary, then streams returned data out with valid/ready. It sits directly upstream of the `hp0_axi_ar*`/`hp0_axi_r*` ports of `top_zynq`. Write channels are out of scope.

## Interface
- `C_HP0_AXI_DATA_WIDTH`, 32: data width in bits; power of 2, 32 or 64.
- `C_HP0_AXI_ADDR_WIDTH`, 32: byte address width.
- `max_burst_len_p`, 16: max beats per burst, 1..16 (AXI3-compatible HP port).
- `len_width_p`, 16: width of the word-count field.

Ports (clock and reset first):
- `aclk` in 1: sole clock; every register is clocked on its rising edge.
- `areset` in 1: asynchronous, active-high reset.
- `cmd_v_i` in 1: command valid.
- `cmd_addr_i` in C_HP0_AXI_ADDR_WIDTH: start byte address; low log2(bytes/word) bits are ignored and forced to 0.
- `cmd_words_i` in len_width_p: word count.
- `cmd_ready_o` out 1: block is idle and accepts a command.
- `data_v_o` out 1, `data_o` out C_HP0_AXI_DATA_WIDTH, `data_ready_i` in 1: output stream.
- `busy_o` out 1: high whenever state != IDLE.
- `err_o` out 1: sticky error flag.
- `hp0_axi_araddr` out ADDR_WIDTH, `hp0_axi_arvalid` out 1, `hp0_axi_arready` in 1, `hp0_axi_arid` out 6, `hp0_axi_arlock` out 1, `hp0_axi_arcache` out 4, `hp0_axi_arprot` out 3, `hp0_axi_arlen` out 8, `hp0_axi_arsize` out 3, `hp0_axi_arburst` out 2, `hp0_axi_arqos` out 4.
- `hp0_axi_rdata` in DATA_WIDTH, `hp0_axi_rvalid` in 1, `hp0_axi_rready` out 1, `hp0_axi_rid` in 6, `hp0_axi_rlast` in 1, `hp0_axi_rresp` in 2.

## Operation
- FSM states: IDLE, ADDR, DATA. Reset state is IDLE.
- IDLE: `cmd_ready_o`=1. On `cmd_v_i & cmd_ready_o`, latch the address and word count and clear `err_o`. If count=0, stay in IDLE and issue no transaction. Otherwise go to ADDR.
- Burst sizing, computed in ADDR: beats = min(remaining, max_burst_len_p, words until the next 4 KB boundary). `arlen` = beats-1, zero-extended to 8 bits.
- Constant AR fields: `arsize`=log2(DATA_WIDTH/8), `arburst`=2'b01 (INCR), `arid`=0, `arlock`=0, `arcache`=4'b0011, `arprot`=3'b000, `arqos`=0.
- ADDR: `arvalid`=1 and `araddr`/`arlen` are held stable until `arready`. On the handshake, load the beat counter with beats and go to DATA.
- DATA: `hp0_axi_rready`=`data_ready_i`, `data_v_o`=`hp0_axi_rvalid`, and `data_o`=`hp0_axi_rdata`. All three are combinational pass-through.
- On each R handshake: decrement the beat counter and the remaining count, and advance the address by bytes/word.
- When the beat counter reaches 0, the burst ends. The beat counter is authoritative and `rlast` is ignored unless the checking macro is enabled (see Configuration).
  - remaining=0: go to IDLE.
  - remaining≠0: go to ADDR.
- `rresp` ≠ 2'b00 on any beat sets `err_o`. The beat is still forwarded and the transfer completes normally.
- `rid` is ignored.

## Timing
- Reset values: `cmd_ready_o`=1, `busy_o`=0, `err_o`=0, `arvalid`=0, `data_v_o`=0, `rready`=0. `araddr`=0, `arlen`=0. Constant AR fields hold their fixed values at all times.
- `arvalid` rises in the cycle after command accept.
- Between bursts, `arvalid` rises in the cycle after the last beat of the previous burst. At most one burst is outstanding.
- Data path has zero-cycle latency. There is no buffering; backpressure from `data_ready_i` propagates directly to `rready`.
- `cmd_ready_o` rises in the cycle after the final beat handshake.
- `areset` asserted mid-transfer returns the block to IDLE immediately and drops `arvalid`/`rready`. The system resets the interconnect together with this block.
- Command accept while `err_o`=1: `err_o` reads 0 from the next cycle.

## Configuration
- `HP0_RD_RLAST_CHECK_EN` defined:
  - A beat with `rlast`=1 while the beat counter is not 1 sets `err_o`.
  - The final beat arriving with `rlast`=0 also sets `err_o`.
  - The beat counter still governs burst termination.
- `HP0_RD_RLAST_CHECK_EN` not defined: `rlast` is unused and only `rresp` can set `err_o`.

## Test plan
- Command addr=0x1000, words=4, slave always ready: one AR with arlen=3, araddr=0x1000. Output is 4 beats in order, then `cmd_ready_o`=1, `err_o`=0.
- Command addr=0x2000, words=40, max_burst_len_p=16: ARs at 0x2000/len 15, 0x2040/len 15, 0x2080/len 7. Output is 40 beats total.
- Command addr=0x0FF8, words=8 (32-bit data): ARs at 0x0FF8/len 1 and 0x1000/len 5, with no burst crossing the 4 KB boundary.
- Command words=0: no `arvalid` asserted, and `cmd_ready_o` stays 1 in the next cycle.
- `data_ready_i` toggled randomly and `arready` delayed 3 cycles: `rready` mirrors `data_ready_i` and `araddr`/`arlen` stay stable while `arvalid`=1. With rresp=2'b10 on beat 2, `err_o`=1 until the next command accept.
- With `HP0_RD_RLAST_CHECK_EN` defined, drive words=4 with `rlast` on beat 3: `err_o`=1, yet 4 beats are still delivered.
